// File: rtl/din_debounce_pkg.sv
// debounce_defs: shared state encodings and defaults for input debouncers
package debounce_defs;
  typedef enum logic [1:0] {
    ST_LO  = 2'b00,
    CHK_HI = 2'b01,
    ST_HI  = 2'b11,
    CHK_LO = 2'b10
  } state_t;
  localparam int DEF_STABLE_CYCLES = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= 2'b00;
    else        {q, s1} <= {s1, d};
endmodule

// File: rtl/din_debounce.sv
// din_debounce: synchronize and glitch-filter din into q_db with edge pulses
module din_debounce
  import debounce_defs::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q_db,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s2;
  logic [CNT_W-1:0] cnt;
  state_t state;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(din), .q(s2));
  assign busy = (state == CHK_HI) || (state == CHK_LO);
  // the count restarts on every CHK entry, so it never exceeds LAST
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_LO;
      cnt   <= '0;
      q_db  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO:
          if (s2) begin
            state <= CHK_HI;
            cnt   <= '0;
          end
        CHK_HI:
          if (!s2) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_HI;
            q_db  <= 1'b1;
            rise  <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        ST_HI:
          if (!s2) begin
            state <= CHK_LO;
            cnt   <= '0;
          end
        CHK_LO:
          if (s2) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_LO;
            q_db  <= 1'b0;
            fall  <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
      endcase
    end
endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce: randomized scoreboard bench against a sample-history reference model
module tb_din_debounce;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic q_db, rise, fall, busy;
  int checks = 0;
  int errors = 0;
  logic raw[$];
  logic hist[$];
  logic [3:0] dq[$];
  logic mq = 1'b0;

  din_debounce #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .q_db(q_db), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    logic seen, old;
    bit flip;
    if (!rst_n) begin
      raw.delete();
      hist.delete();
      dq.delete();
      mq = 1'b0;
    end else begin
      raw.push_back(din);
      if (raw.size() > 3) void'(raw.pop_front());
      seen = (raw.size() == 3) ? raw[0] : 1'b0;
      hist.push_back(seen);
      if (hist.size() > S + 1) void'(hist.pop_front());
      old = mq;
      flip = (hist.size() == S + 1);
      foreach (hist[i]) if (hist[i] == old) flip = 1'b0;
      if (flip) mq = seen;
      dq.push_back({mq, flip && !old, flip && old, seen != mq});
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp;
    exp = (!rst_n || dq.size() == 0) ? 4'b0000 : dq.pop_front();
    checks++;
    if ({q_db, rise, fall, busy} !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t got q/r/f/b=%b%b%b%b want %b", $time, q_db, rise, fall, busy, exp);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check_zero(input string tag);
    checks++;
    if ({q_db, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset %s t=%0t got q/r/f/b=%b%b%b%b want 0000", tag, $time, q_db, rise, fall, busy);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset(input int hold_edges);
    rst_n = 1'b0;
    repeat (hold_edges) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    din = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("initial");
    #11 rst_n = 1'b1;
    drive(0, 20);
    drive(1, 10);
    drive(0, 10);
    drive(1, 3);
    drive(0, 10);
    drive(1, S);
    drive(0, 10);
    drive(1, S + 1);
    drive(1, 5);
    drive(0, S);
    drive(1, 10);
    drive(0, 12);
    din = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid-check");
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1, 12);
    drive(0, 12);
    for (int i = 0; i < 10; i++) drive(logic'(i % 2), 1);
    drive(1, 12);
    repeat (300) drive(logic'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    #1 pulse_reset(2);
    repeat (200) drive(logic'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    repeat (3) @(negedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
